uart_rx_buffered: RTL and testbench

- Parametrised, synthesizable UART receiver with a receive FIFO. It succeeds the fixed 217-clock, 8N1, single-sample bench monitor used in integration tests.
- Runtime-configurable bit period, data width (5-8), parity and stop bits.
- Majority-vote sampling, framing/parity/break detection and sticky overrun.
- Sits on the tinyQV peripheral side as a real UART RX. The same block is instantiated in benches as the UART monitor.

---
 rtl/uart_rx_pkg.sv | 26 ++
 rtl/sync_fifo_fwft.sv | 53 +++++
 rtl/uart_rx_buffered.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx_buffered.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the buffered UART receiver.
// Holds the receive FSM states, the FIFO entry layout and the majority-vote helper.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    // FIFO entry layout: {break, parity_err, frame_err, data[7:0]}
    localparam int BRK_BIT  = 10;
    localparam int PERR_BIT = 9;
    localparam int FERR_BIT = 8;
    localparam int ENTRY_W  = 11;

    localparam int MIN_DIV = 16;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; the head entry is visible whenever not empty.
// A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module sync_fifo_fwft #(
    parameter  int WIDTH = 11,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Empty reads return zero so the head bus is never stale or unknown.
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // NOTE: the storage array has no reset; only the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver with runtime frame format, majority-vote sampling, error/break flags
// and a first-word-fall-through receive FIFO with sticky overrun.
module uart_rx_buffered
    import uart_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 12,
    parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rxd,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [1:0]       cfg_data_bits,
    input  logic             cfg_parity_en,
    input  logic             cfg_parity_odd,
    input  logic             cfg_stop2,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [7:0]       rd_data,
    output logic             rd_frame_err,
    output logic             rd_parity_err,
    output logic             rd_break,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overrun,
    input  logic             clr_overrun,
    output logic             busy
);

    rx_state_e        state;
    rx_state_e        state_nxt;
    logic             sync1;
    logic             sync2;
    logic [1:0]       hist;
    logic             voted;
    logic             fall_edge;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       bits_q;
    logic             par_en_q;
    logic             odd_q;
    logic             stop2_q;
    logic [2:0]       bit_idx;
    logic             stop_idx;
    logic [7:0]       shreg;
    logic             par_bit;
    logic             ferr_q;
    logic             sample;
    logic             last_bit;
    logic             brk_now;
    logic             frame_done;
    logic             perr_calc;
    logic             push_q;
    logic [ENTRY_W-1:0] entry_q;
    logic [ENTRY_W-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 2'b11;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
            hist  <= {hist[0], sync2};
        end
    end

    assign voted     = majority3({hist, sync2});
    assign fall_edge = hist[0] & ~sync2;
    assign last_bit  = (bit_idx == ({1'b0, bits_q} + 3'd4));
    assign perr_calc = par_en_q & ~brk_now & (^shreg ^ par_bit ^ odd_q);

    // Break is decided on the first stop sample so one long low ends the frame early.
    assign brk_now    = (state == STOP) && sample && !stop_idx && !voted
                        && (shreg == 8'h00) && (!par_en_q || !par_bit);
    assign frame_done = (state == STOP) && sample && (brk_now || (stop_idx == stop2_q));

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        sample = 1'b0;
        case (state)
            START:              sample = (cnt == (div_q >> 1));
            DATA, PARITY, STOP: sample = (cnt == div_q - DIV_W'(1));
            default:            sample = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (fall_edge) state_nxt = START;
            START:     if (sample) state_nxt = voted ? IDLE : DATA;
            DATA:      if (sample && last_bit) state_nxt = par_en_q ? PARITY : STOP;
            PARITY:    if (sample) state_nxt = STOP;
            STOP:      if (frame_done) state_nxt = brk_now ? WAIT_HIGH : IDLE;
            WAIT_HIGH: if (sync2) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            div_q    <= DIV_W'(MIN_DIV);
            bits_q   <= 2'd3;
            par_en_q <= 1'b0;
            odd_q    <= 1'b0;
            stop2_q  <= 1'b0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            ferr_q   <= 1'b0;
            push_q   <= 1'b0;
            entry_q  <= '0;
        end else begin
            push_q <= frame_done;
            if (state == IDLE || state == WAIT_HIGH || sample) cnt <= '0;
            else                                               cnt <= cnt + DIV_W'(1);

            // Frame format is frozen at the start edge for the whole frame.
            if (state == IDLE && fall_edge) begin
                div_q    <= (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;
                bits_q   <= cfg_data_bits;
                par_en_q <= cfg_parity_en;
                odd_q    <= cfg_parity_odd;
                stop2_q  <= cfg_stop2;
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                shreg    <= '0;
                par_bit  <= 1'b0;
                ferr_q   <= 1'b0;
            end

            if (state == DATA && sample) begin
                shreg[bit_idx] <= voted;
                bit_idx        <= bit_idx + 3'd1;
            end
            if (state == PARITY && sample) par_bit <= voted;
            if (state == STOP && sample) begin
                stop_idx <= 1'b1;
                if (!voted) ferr_q <= 1'b1;
            end
            if (frame_done) entry_q <= {brk_now, perr_calc, ferr_q | ~voted, shreg};
        end
    end

    sync_fifo_fwft #(
        .WIDTH(ENTRY_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_q),
        .push_data (entry_q),
        .pop       (rd_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // A full FIFO loses the new frame unless the consumer pops in the same cycle; set wins over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               overrun <= 1'b0;
        else if (push_q && fifo_full && !rd_ready) overrun <= 1'b1;
        else if (clr_overrun)                     overrun <= 1'b0;
    end

    assign rd_valid      = !fifo_empty;
    assign rd_data       = head[7:0];
    assign rd_frame_err  = head[FERR_BIT];
    assign rd_parity_err = head[PERR_BIT];
    assign rd_break      = head[BRK_BIT];
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench for uart_rx_buffered: directed serial frames push expected entries,
// an independent monitor pops and compares every entry the DUT hands out.
module tb_uart_rx_buffered;

    localparam int FIFO_DEPTH = 8;
    localparam int DIV_W      = 12;
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rxd = 1'b1;
    logic [DIV_W-1:0] cfg_div;
    logic [1:0]       cfg_data_bits;
    logic             cfg_parity_en;
    logic             cfg_parity_odd;
    logic             cfg_stop2;
    logic             rd_valid;
    logic             rd_ready;
    logic [7:0]       rd_data;
    logic             rd_frame_err;
    logic             rd_parity_err;
    logic             rd_break;
    logic [LVL_W-1:0] fifo_level;
    logic             overrun;
    logic             clr_overrun;
    logic             busy;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
        logic       brk;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_popped = 0;
    int   div = 217;
    bit   abort = 1'b0;

    uart_rx_buffered #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .DIV_W(DIV_W),
        .LVL_W(LVL_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd), .cfg_div(cfg_div),
        .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en),
        .cfg_parity_odd(cfg_parity_odd), .cfg_stop2(cfg_stop2),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_frame_err(rd_frame_err), .rd_parity_err(rd_parity_err), .rd_break(rd_break),
        .fifo_level(fifo_level), .overrun(overrun), .clr_overrun(clr_overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expect_entry(input logic [7:0] d, input logic f, input logic p, input logic b);
        exp_t e;
        e.data = d; e.ferr = f; e.perr = p; e.brk = b;
        exp_q.push_back(e);
    endtask

    task automatic set_cfg(input int d, input logic [1:0] bits, input logic pen, input logic podd, input logic s2);
        div            = d;
        cfg_div        = DIV_W'(d);
        cfg_data_bits  = bits;
        cfg_parity_en  = pen;
        cfg_parity_odd = podd;
        cfg_stop2      = s2;
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        for (int i = 0; i < div; i++) begin
            if (abort) begin
                rxd = 1'b1;
                return;
            end
            rxd = (glitch && i == div / 2) ? ~b : b;
            @(negedge clk);
        end
    endtask

    // Frame format follows the current cfg_* inputs; parity is generated here, flip_par corrupts it.
    task automatic send_frame(input logic [7:0] d, input bit flip_par, input logic stop_val, input int glitch_bit);
        int   nbits;
        logic p;
        nbits = int'(cfg_data_bits) + 5;
        p     = cfg_parity_odd ^ flip_par;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            send_bit(d[i], i == glitch_bit);
            p ^= d[i];
        end
        if (cfg_parity_en) send_bit(p, 1'b0);
        send_bit(stop_val, 1'b0);
        if (cfg_stop2) send_bit(1'b1, 1'b0);
        rxd = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        rxd = 1'b1;
        repeat (n * div) @(negedge clk);
    endtask

    task automatic wait_busy(input logic lvl, input int budget);
        for (int i = 0; i < budget && busy !== lvl; i++) @(negedge clk);
        check("busy_wait", busy, lvl);
    endtask

    task automatic drain(input int budget);
        rd_ready = 1'b1;
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("drain_left", exp_q.size(), 0);
        check("drain_level", fifo_level, 0);
    endtask

    // Monitor: samples 2 ns after the falling edge, after all stimulus for that half-cycle settled.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (rst_n && rd_valid && rd_ready) begin
            n_popped++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_entry: got data 0x%0h brk %0b, none expected", rd_data, rd_break);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", rd_data, e.data);
                check("rd_frame_err", rd_frame_err, e.ferr);
                check("rd_parity_err", rd_parity_err, e.perr);
                check("rd_break", rd_break, e.brk);
            end
        end
    end

    initial begin
        int pops_before;
        set_cfg(217, 2'd3, 1'b0, 1'b0, 1'b0);
        rd_ready    = 1'b0;
        clr_overrun = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {rd_break, rd_parity_err, rd_frame_err}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("no_start_on_release", busy, 0);

        // 8N1 at 217 clocks per bit, three back-to-back frames held in the FIFO
        expect_entry(8'h4F, 0, 0, 0);
        expect_entry(8'h4B, 0, 0, 0);
        expect_entry(8'h0A, 0, 0, 0);
        send_frame(8'h4F, 0, 1'b1, -1);
        send_frame(8'h4B, 0, 1'b1, -1);
        send_frame(8'h0A, 0, 1'b1, -1);
        repeat (4) @(negedge clk);
        check("level_three", fifo_level, 3);
        check("valid_three", rd_valid, 1);
        drain(50);

        // 7E1 then 7O2, each with correct and flipped parity
        set_cfg(48, 2'd2, 1'b1, 1'b0, 1'b0);
        expect_entry(8'h35, 0, 0, 0);
        send_frame(8'h35, 0, 1'b1, -1);
        expect_entry(8'h35, 0, 1, 0);
        send_frame(8'h35, 1, 1'b1, -1);
        idle_bits(1);
        set_cfg(48, 2'd2, 1'b1, 1'b1, 1'b1);
        expect_entry(8'h35, 0, 0, 0);
        send_frame(8'h35, 0, 1'b1, -1);
        expect_entry(8'h35, 0, 1, 0);
        send_frame(8'h35, 1, 1'b1, -1);
        idle_bits(1);
        drain(50);

        // Framing error, then a 20-bit break yielding exactly one entry
        set_cfg(48, 2'd3, 1'b0, 1'b0, 1'b0);
        pops_before = n_popped;
        expect_entry(8'hA5, 1, 0, 0);
        send_frame(8'hA5, 0, 1'b0, -1);
        idle_bits(2);
        expect_entry(8'h00, 1, 0, 1);
        rxd = 1'b0;
        repeat (19 * div) @(negedge clk);
        check("busy_in_break", busy, 1);
        repeat (div) @(negedge clk);
        rxd = 1'b1;
        repeat (6) @(negedge clk);
        check("busy_after_break", busy, 0);
        idle_bits(1);
        drain(50);
        check("break_entry_count", n_popped - pops_before, 2);

        // False start glitch and a single-clock glitch at a data-bit centre
        pops_before = n_popped;
        rxd = 1'b0;
        repeat (div * 3 / 10) @(negedge clk);
        idle_bits(2);
        check("false_start_idle", busy, 0);
        expect_entry(8'h5A, 0, 0, 0);
        send_frame(8'h5A, 0, 1'b1, 3);
        idle_bits(1);
        drain(50);
        check("glitch_entry_count", n_popped - pops_before, 1);

        // Fill, overrun, clear, then a simultaneous pop and push at full
        set_cfg(32, 2'd3, 1'b0, 1'b0, 1'b0);
        rd_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) expect_entry(8'h10 + 8'(i), 0, 0, 0);
            send_frame(8'h10 + 8'(i), 0, 1'b1, -1);
        end
        repeat (4) @(negedge clk);
        check("level_full", fifo_level, 8);
        check("overrun_set", overrun, 1);
        check("head_intact", rd_data, 8'h10);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        check("overrun_cleared", overrun, 0);
        expect_entry(8'h19, 0, 0, 0);
        fork
            send_frame(8'h19, 0, 1'b1, -1);
            begin
                wait_busy(1'b1, 100);
                wait_busy(1'b0, 20 * div);
                check("level_before_pushpop", fifo_level, 8);
                rd_ready = 1'b1;
                @(negedge clk);
                rd_ready = 1'b0;
                check("level_pushpop", fifo_level, 8);
                check("overrun_pushpop", overrun, 0);
                repeat (3) @(negedge clk);
                check("level_pushpop_hold", fifo_level, 8);
            end
        join
        drain(200);
        check("overrun_end", overrun, 0);

        // Reset in the middle of a frame with one entry already queued
        set_cfg(48, 2'd3, 1'b0, 1'b0, 1'b0);
        rd_ready = 1'b0;
        expect_entry(8'h3C, 0, 0, 0);
        send_frame(8'h3C, 0, 1'b1, -1);
        repeat (4) @(negedge clk);
        check("level_before_reset", fifo_level, 1);
        abort = 1'b0;
        fork
            send_frame(8'hC3, 0, 1'b1, -1);
            begin
                repeat (div * 4 + div / 2) @(negedge clk);
                check("busy_mid_frame", busy, 1);
                rst_n = 1'b0;
                abort = 1'b1;
                exp_q.delete();
                #1;
                check("mid_rst_rd_valid", rd_valid, 0);
                check("mid_rst_rd_data", rd_data, 0);
                check("mid_rst_level", fifo_level, 0);
                check("mid_rst_busy", busy, 0);
                check("mid_rst_overrun", overrun, 0);
                check("mid_rst_flags", {rd_break, rd_parity_err, rd_frame_err}, 0);
            end
        join
        abort = 1'b0;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_bits(2);
        check("post_reset_idle", busy, 0);
        rd_ready = 1'b1;
        expect_entry(8'h96, 0, 0, 0);
        send_frame(8'h96, 0, 1'b1, -1);
        idle_bits(1);
        drain(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
